rotary_operand_ctrl: RTL

//   Parametrised successor to the switch/rotary operand controller. Synchronises and

---
 rtl/rotary_operand_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rotary_operand_ctrl.sv
// Rotary-encoder operand editor: synchronises and debounces the encoder and push button,
// decodes detents and edits operands A/B and the opcode selected by a 3-state field FSM.
module rotary_operand_ctrl #(
  parameter int DATA_W          = 8,
  parameter int OP_W            = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SAT_MODE        = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rot_a,
  input  logic              rot_b,
  input  logic              rot_center,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [OP_W-1:0]   opCode,
  output logic [1:0]        field_sel,
  output logic              update
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DATA_W-1:0] DATA_MAX = '1;

  typedef enum logic [1:0] {
    FIELD_A  = 2'd0,
    FIELD_B  = 2'd1,
    FIELD_OP = 2'd2
  } field_t;

  // Bit 0 = channel A, bit 1 = channel B, bit 2 = push button.
  logic [2:0]       raw, sync1, sync2, deb, deb_d;
  logic [CNT_W-1:0] cnt [3];

  field_t            state, state_next;
  logic [DATA_W-1:0] a_next, b_next;
  logic [OP_W-1:0]   op_next;
  logic              step, step_cw, press, changed, changed_q;

  assign raw = {rot_center, rot_b, rot_a};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only a rising edge of debounced A is a detent; B's level gives the direction.
  assign step    = deb[0] & ~deb_d[0];
  assign step_cw = ~deb[1];
  assign press   = deb[2] & ~deb_d[2];

  function automatic logic [DATA_W-1:0] adj_data(input logic [DATA_W-1:0] v, input logic up);
    if (up) begin
      if (SAT_MODE != 0 && v == DATA_MAX) return v;
      return v + 1'b1;
    end
    if (SAT_MODE != 0 && v == '0) return v;
    return v - 1'b1;
  endfunction

  always_comb begin
    a_next     = A;
    b_next     = B;
    op_next    = opCode;
    state_next = state;
    // The step edits the field selected before any same-cycle press takes effect.
    if (step) begin
      case (state)
        FIELD_A:  a_next  = adj_data(A, step_cw);
        FIELD_B:  b_next  = adj_data(B, step_cw);
        FIELD_OP: op_next = step_cw ? opCode + 1'b1 : opCode - 1'b1;
        default:  ;
      endcase
    end
    case (state)
      FIELD_A:  if (press) state_next = FIELD_B;
      FIELD_B:  if (press) state_next = FIELD_OP;
      FIELD_OP: if (press) state_next = FIELD_A;
      default:  state_next = FIELD_A;
    endcase
    changed = (a_next != A) || (b_next != B) || (op_next != opCode) || (state_next != state);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      A         <= '0;
      B         <= '0;
      opCode    <= '0;
      state     <= FIELD_A;
      changed_q <= 1'b0;
      update    <= 1'b0;
    end else begin
      A         <= a_next;
      B         <= b_next;
      opCode    <= op_next;
      state     <= state_next;
      changed_q <= changed;
      update    <= changed_q;
    end
  end

  assign field_sel = state;

endmodule
